g1_update_scheduler: RTL and testbench
======================================

G1_UPDATE_SCHEDULER -- requirements
Module: g1_update_scheduler

Interface
REQ-001 Parameters: INDEX_BIT_LEN, default 11, table index width; PACKET_BIT_LEN, default 104, tuple width; ENTRY_DATA_WIDTH, default 98, entry width; MAX_HOPS, default 8, chain-walk limit; UPD_BURST, default 4, maximum consecutive updates while a lookup waits.
REQ-002 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 search_valid / search_ready  in / out  1 / 1  lookup request handshake.
REQ-006 search_tuple  in  PACKET_BIT_LEN  packet header to classify.
REQ-007 search_start_index  in  INDEX_BIT_LEN  chain head index.
REQ-008 upd_valid / upd_ready  in / out  1 / 1  table-write request handshake.
REQ-009 upd_index / upd_data  in  INDEX_BIT_LEN / ENTRY_DATA_WIDTH  write address and entry.
REQ-010 res_valid / res_match / res_ruleID  out  1 / 1 / INDEX_BIT_LEN  lookup result.
REQ-011 tbl_we / tbl_index / tbl_din / tbl_tuple  out  1 / INDEX_BIT_LEN / ENTRY_DATA_WIDTH / PACKET_BIT_LEN  shared G1 table port.
REQ-012 tbl_match / tbl_ruleID / tbl_next_index  in  1 / INDEX_BIT_LEN / INDEX_BIT_LEN  table registered outputs, valid one cycle after issue.

Function
REQ-013 FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESULT.
REQ-014 Handshakes: a transfer occurs when valid and ready are both high on a clk edge; each ready is high only in IDLE and only for the request granted that cycle.
REQ-015 Arbitration in IDLE: updates win over searches, except that once burst_cnt reaches UPD_BURST while search_valid is high, the pending search wins.
REQ-016 burst_cnt SHALL increment on each update accepted while search_valid is high, saturate at UPD_BURST, and clear on any search acceptance or whenever search_valid is low in IDLE.
REQ-017 WRITE: tbl_we=1, tbl_index=upd_index, tbl_din=upd_data for exactly one cycle, then return to IDLE. An update therefore occupies 2 cycles per request.
REQ-018 On search acceptance, latch the tuple and start index, set hop_cnt=0, and go to RD_ISSUE.
REQ-019 RD_ISSUE: drive tbl_index with the current index and tbl_tuple with the latched tuple, with tbl_we=0, then go to RD_WAIT.
REQ-020 RD_WAIT: sample tbl_match, tbl_ruleID and tbl_next_index. Outcomes:
- match=1: result hit, go to RESULT.
- next_index==0 (null) or hop_cnt==MAX_HOPS-1: result miss, go to RESULT.
- otherwise: current index becomes next_index, hop_cnt increments, go to RD_ISSUE.
REQ-021 tbl_match SHALL be qualified only in the RD_WAIT cycle; it is ignored in every other state.
REQ-022 RESULT: res_valid=1 for exactly one cycle, with res_match and res_ruleID held stable that cycle; res_ruleID=0 on a miss. Then go to IDLE.
REQ-023 Updates SHALL NOT be accepted from search acceptance through RESULT, so every chain walk is atomic.
REQ-024 Lookup latency from acceptance to res_valid is 2*h+1 cycles for h table reads, h between 1 and MAX_HOPS.
REQ-025 Outside WRITE, tbl_we=0 and tbl_din holds its last value; outside RD_ISSUE, tbl_index and tbl_tuple hold their last value.
REQ-026 A search_start_index of 0 SHALL still perform one read.
REQ-027 Simultaneous upd_valid and search_valid with burst_cnt<UPD_BURST: the update is accepted and the search waits with ready low.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, burst_cnt=0, hop_cnt=0, and all outputs to 0.
REQ-029 Reset during a walk or write SHALL drop that operation; no res_valid and no tbl_we are produced after release.
REQ-030 The first handshake after reset is possible on the first clk edge with rst_n high.

Configuration
REQ-031 Macro G1_SCHED_STATS_EN.
- Defined: adds outputs stat_lookups and stat_updates, each 16 bits and saturating at 0xFFFF, incremented on RESULT and on WRITE respectively, and cleared by reset.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-032 Update index 5, data 0xA, no search pending -> tbl_we=1, tbl_index=5, tbl_din=0xA in the cycle after acceptance; upd_ready high again 2 cycles after acceptance.
REQ-033 Search, start index 3, table matches at first read with ruleID 7 -> res_valid 3 cycles after acceptance, res_match=1, res_ruleID=7.
REQ-034 Chain 3->9->0 with no match -> two reads at indices 3 and 9, res_match=0, res_ruleID=0, latency 5 cycles.
REQ-035 Search held valid while 6 updates are queued, UPD_BURST=4 -> exactly 4 updates accepted, then the search is accepted; no update accepted until res_valid.
REQ-036 Cyclic chain 1->2->1, MAX_HOPS=8 -> exactly 8 reads, then a miss result.
REQ-037 rst_n pulsed low during RD_WAIT -> outputs 0 immediately; no res_valid afterward; next search completes normally.

Source files
------------

// File: rtl/g1_update_scheduler.sv
// g1_update_scheduler: shares one G1 table port between entry writes and chained lookups.
// Latency: an update occupies 2 cycles; a lookup of h reads returns res_valid 2*h+1 cycles after acceptance.
// Backpressure: readies are high only in IDLE for the granted request; G1_SCHED_STATS_EN adds stat counters.
module g1_update_scheduler #(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int PACKET_BIT_LEN   = 104,
  parameter int ENTRY_DATA_WIDTH = 98,
  parameter int MAX_HOPS         = 8,
  parameter int UPD_BURST        = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        search_valid,
  output logic                        search_ready,
  input  logic [PACKET_BIT_LEN-1:0]   search_tuple,
  input  logic [INDEX_BIT_LEN-1:0]    search_start_index,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [INDEX_BIT_LEN-1:0]    upd_index,
  input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
  output logic                        res_valid,
  output logic                        res_match,
  output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
  output logic                        tbl_we,
  output logic [INDEX_BIT_LEN-1:0]    tbl_index,
  output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
  output logic [PACKET_BIT_LEN-1:0]   tbl_tuple,
  input  logic                        tbl_match,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index
`ifdef G1_SCHED_STATS_EN
  ,
  output logic [15:0]                 stat_lookups,
  output logic [15:0]                 stat_updates
`endif
);

  localparam int HOP_W   = (MAX_HOPS > 1) ? $clog2(MAX_HOPS) : 1;
  localparam int BURST_W = $clog2(UPD_BURST + 1);
  localparam logic [HOP_W-1:0]   HOP_LAST  = HOP_W'(MAX_HOPS - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(UPD_BURST);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESULT} state_t;

  state_t             state, state_nxt;
  logic [BURST_W-1:0] burst_cnt;
  logic [HOP_W-1:0]   hop_cnt;
  logic               grant_srch, grant_upd;
  logic               walk_hit, walk_miss, walk_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: walks loop RD_ISSUE/RD_WAIT until hit, null link or hop limit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_upd)       state_nxt = WRITE;
        else if (grant_srch) state_nxt = RD_ISSUE;
      end
      WRITE:    state_nxt = IDLE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = (walk_hit || walk_miss) ? RESULT : RD_ISSUE;
      RESULT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output/decision logic: update-first arbitration with a burst cap, and table response decode
  always_comb begin
    grant_srch   = (state == IDLE) && search_valid && (!upd_valid || burst_cnt == BURST_MAX);
    grant_upd    = (state == IDLE) && upd_valid && !grant_srch;
    // readies are forced low while reset is asserted so every output reads 0
    search_ready = rst_n && grant_srch;
    upd_ready    = rst_n && grant_upd;
    walk_hit     = (state == RD_WAIT) && tbl_match;
    walk_miss    = (state == RD_WAIT) && !tbl_match &&
                   (tbl_next_index == '0 || hop_cnt == HOP_LAST);
    walk_next    = (state == RD_WAIT) && !walk_hit && !walk_miss;
  end

  // Table port, walk bookkeeping and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_we     <= 1'b0;
      tbl_index  <= '0;
      tbl_din    <= '0;
      tbl_tuple  <= '0;
      hop_cnt    <= '0;
      res_valid  <= 1'b0;
      res_match  <= 1'b0;
      res_ruleID <= '0;
    end else begin
      // tbl_we is high exactly during the WRITE cycle that follows the grant
      tbl_we <= grant_upd;
      if (grant_upd) begin
        tbl_index <= upd_index;
        tbl_din   <= upd_data;
      end else if (grant_srch) begin
        tbl_index <= search_start_index;
        tbl_tuple <= search_tuple;
      end else if (walk_next) begin
        tbl_index <= tbl_next_index;
      end

      if (grant_srch)     hop_cnt <= '0;
      else if (walk_next) hop_cnt <= hop_cnt + 1'b1;

      res_valid <= walk_hit || walk_miss;
      if (walk_hit) begin
        res_match  <= 1'b1;
        res_ruleID <= tbl_ruleID;
      end else if (walk_miss) begin
        res_match  <= 1'b0;
        res_ruleID <= '0;
      end
    end
  end

  // Burst counter: counts updates that jumped ahead of a waiting search
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_srch || !search_valid)           burst_cnt <= '0;
      else if (grant_upd && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
    end
  end

`ifdef G1_SCHED_STATS_EN
  // Saturating activity counters for completed lookups and issued writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups <= '0;
      stat_updates <= '0;
    end else begin
      if (state == RESULT && stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 1'b1;
      if (state == WRITE  && stat_updates != 16'hFFFF) stat_updates <= stat_updates + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_g1_update_scheduler.sv
// tb_g1_update_scheduler: directed vector table, burst/reset sequences and randomized traffic
// against a chain-walk reference model and a registered table model.
module tb_g1_update_scheduler;
  localparam int IW = 11;
  localparam int PW = 104;
  localparam int DW = 98;
  localparam int MH = 8;
  localparam int UB = 4;
  localparam int NT = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          search_valid, search_ready;
  logic [PW-1:0] search_tuple;
  logic [IW-1:0] search_start_index;
  logic          upd_valid, upd_ready;
  logic [IW-1:0] upd_index;
  logic [DW-1:0] upd_data;
  logic          res_valid, res_match;
  logic [IW-1:0] res_ruleID;
  logic          tbl_we;
  logic [IW-1:0] tbl_index;
  logic [DW-1:0] tbl_din;
  logic [PW-1:0] tbl_tuple;
  logic          tbl_match;
  logic [IW-1:0] tbl_ruleID, tbl_next_index;
`ifdef G1_SCHED_STATS_EN
  logic [15:0]   stat_lookups, stat_updates;
`endif

  always #5 clk = ~clk;

  g1_update_scheduler #(
    .INDEX_BIT_LEN(IW), .PACKET_BIT_LEN(PW), .ENTRY_DATA_WIDTH(DW),
    .MAX_HOPS(MH), .UPD_BURST(UB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .search_valid(search_valid), .search_ready(search_ready),
    .search_tuple(search_tuple), .search_start_index(search_start_index),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_data(upd_data),
    .res_valid(res_valid), .res_match(res_match), .res_ruleID(res_ruleID),
    .tbl_we(tbl_we), .tbl_index(tbl_index), .tbl_din(tbl_din), .tbl_tuple(tbl_tuple),
    .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID), .tbl_next_index(tbl_next_index)
`ifdef G1_SCHED_STATS_EN
    , .stat_lookups(stat_lookups), .stat_updates(stat_updates)
`endif
  );

  // table contents: link, hit enable, 16-bit key compared to tuple[15:0], rule id
  logic [IW-1:0] mem_next [NT];
  bit            mem_hit  [NT];
  logic [15:0]   mem_key  [NT];
  logic [IW-1:0] mem_rule [NT];

  // registered table read, responses valid one cycle after the index is presented
  always @(posedge clk) begin
    tbl_match      <= mem_hit[tbl_index] && (tbl_tuple[15:0] == mem_key[tbl_index]);
    tbl_ruleID     <= mem_rule[tbl_index];
    tbl_next_index <= mem_next[tbl_index];
  end

  typedef struct { bit m; logic [IW-1:0] r; int h; } exp_t;
  typedef struct { logic [IW-1:0] i; logic [DW-1:0] d; int c; } wr_t;
  typedef struct { logic [IW-1:0] st; logic [15:0] key; bit m; logic [IW-1:0] r; int h; } vec_t;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   n_acc = 0, n_uacc = 0, n_res = 0, u_at_sacc = 0, u_at_res = 0;
  int   bc = 0;
  bit   srch_out = 1'b0;
  exp_t exp_q[$];
  int   acc_q[$];
  wr_t  wr_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // reference chain walk: follow links from the start index until hit, null link or hop limit
  task automatic walk(input logic [IW-1:0] st, input logic [PW-1:0] tp, output exp_t e);
    logic [IW-1:0] idx;
    idx = st; e.m = 1'b0; e.r = '0; e.h = 0;
    for (int i = 0; i < MH; i++) begin
      e.h = i + 1;
      if (mem_hit[idx] && tp[15:0] == mem_key[idx]) begin
        e.m = 1'b1; e.r = mem_rule[idx]; break;
      end
      if (mem_next[idx] == '0) break;
      idx = mem_next[idx];
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: handshakes, arbitration rule, write and result scoreboards
  bit   m_u, m_s;
  wr_t  m_w;
  exp_t m_e;
  int   m_a;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); acc_q.delete(); wr_q.delete(); bc = 0; srch_out = 1'b0;
      end else begin
        m_u = upd_valid && upd_ready;
        m_s = search_valid && search_ready;
        if (m_u || m_s)
          chk("grant", 128'({m_u, m_s}),
              128'((upd_valid && !(search_valid && bc == UB)) ? 2'b10 : 2'b01));
        if (m_u) begin
          chk("upd_during_walk", 128'(srch_out), 128'(0));
          wr_q.push_back('{upd_index, upd_data, cyc + 1});
          n_uacc++;
        end
        if (m_s) begin
          srch_out = 1'b1; acc_q.push_back(cyc); n_acc++; u_at_sacc = n_uacc;
        end
        if (m_s || !search_valid) bc = 0;
        else if (m_u && bc < UB) bc++;
        if (tbl_we) begin
          if (wr_q.size() == 0) chk("unexpected_tbl_we", 128'(tbl_we), 128'(0));
          else begin
            m_w = wr_q.pop_front();
            chk("wr_index", 128'(tbl_index), 128'(m_w.i));
            chk("wr_data", 128'(tbl_din), 128'(m_w.d));
            chk("wr_cycle", 128'(cyc), 128'(m_w.c));
          end
        end
        if (res_valid) begin
          if (exp_q.size() == 0 || acc_q.size() == 0)
            chk("unexpected_res_valid", 128'(res_valid), 128'(0));
          else begin
            m_e = exp_q.pop_front(); m_a = acc_q.pop_front();
            chk("res_match", 128'(res_match), 128'(m_e.m));
            chk("res_ruleID", 128'(res_ruleID), 128'(m_e.r));
            chk("res_latency", 128'(cyc - m_a), 128'(2 * m_e.h + 1));
          end
          srch_out = 1'b0; n_res++; u_at_res = n_uacc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_search(input logic [IW-1:0] st, input logic [PW-1:0] tp, input exp_t e);
    int b0, r0, k;
    b0 = n_acc; r0 = n_res; k = 0;
    exp_q.push_back(e);
    search_valid = 1'b1; search_start_index = st; search_tuple = tp;
    while (n_acc == b0 && k < 300) begin tick(); k++; end
    search_valid = 1'b0;
    if (n_acc == b0) begin
      chk("search_accept_timeout", 128'(n_acc - b0), 128'(1));
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      return;
    end
    k = 0;
    while (n_res == r0 && k < 100) begin tick(); k++; end
    if (n_res == r0) chk("result_timeout", 128'(n_res - r0), 128'(1));
  endtask

  // presents one update and holds it until accepted; caller decides when valid drops
  task automatic do_upd1(input logic [IW-1:0] idx, input logic [DW-1:0] d);
    int b0, k;
    b0 = n_uacc; k = 0;
    upd_valid = 1'b1; upd_index = idx; upd_data = d;
    while (n_uacc == b0 && k < 300) begin tick(); k++; end
    if (n_uacc == b0) chk("upd_accept_timeout", 128'(n_uacc - b0), 128'(1));
  endtask

  function automatic logic [PW-1:0] mk_tuple(input logic [15:0] key);
    logic [PW-1:0] t;
    t = '0;
    t[15:0] = key;
    t[PW-1:PW-32] = $urandom;
    return t;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  vec_t          vt [10];
  exp_t          ev;
  int            base_u, r0, b0, k;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    search_valid = 1'b0; search_tuple = '0; search_start_index = '0;
    upd_valid = 1'b0; upd_index = '0; upd_data = '0;
    for (int i = 0; i < NT; i++) begin
      mem_next[i] = '0; mem_hit[i] = 1'b0; mem_key[i] = '0; mem_rule[i] = '0;
    end
    // chain 3->9->null, 0->9, cycle 1<->2, long chain 10..18
    mem_next[3] = 11'd9; mem_hit[3] = 1'b1; mem_key[3] = 16'h1234; mem_rule[3] = 11'd7;
    mem_next[9] = 11'd0; mem_hit[9] = 1'b1; mem_key[9] = 16'h5555; mem_rule[9] = 11'h21;
    mem_next[1] = 11'd2; mem_next[2] = 11'd1;
    mem_next[0] = 11'd9; mem_hit[0] = 1'b1; mem_key[0] = 16'h0F0F; mem_rule[0] = 11'd11;
    for (int i = 10; i < 18; i++) mem_next[i] = IW'(i + 1);
    mem_hit[18] = 1'b1; mem_key[18] = 16'hAAAA; mem_rule[18] = 11'h3FF;

    vt[0] = '{11'd3,  16'h1234, 1'b1, 11'd7,   1};
    vt[1] = '{11'd3,  16'h7777, 1'b0, 11'd0,   2};
    vt[2] = '{11'd3,  16'h5555, 1'b1, 11'h21,  2};
    vt[3] = '{11'd1,  16'h7777, 1'b0, 11'd0,   8};
    vt[4] = '{11'd0,  16'h0F0F, 1'b1, 11'd11,  1};
    vt[5] = '{11'd0,  16'h7777, 1'b0, 11'd0,   2};
    vt[6] = '{11'd10, 16'hAAAA, 1'b0, 11'd0,   8};
    vt[7] = '{11'd11, 16'hAAAA, 1'b1, 11'h3FF, 8};
    vt[8] = '{11'd17, 16'hAAAA, 1'b1, 11'h3FF, 2};
    vt[9] = '{11'd9,  16'h1234, 1'b0, 11'd0,   1};

    // reset state, with an update already presented
    upd_valid = 1'b1; upd_index = 11'd5; upd_data = 98'hA;
    repeat (3) tick();
    chk("rst_search_ready", 128'(search_ready), 128'(0));
    chk("rst_upd_ready", 128'(upd_ready), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_res_match", 128'(res_match), 128'(0));
    chk("rst_res_ruleID", 128'(res_ruleID), 128'(0));
    chk("rst_tbl_we", 128'(tbl_we), 128'(0));
    chk("rst_tbl_index", 128'(tbl_index), 128'(0));
    chk("rst_tbl_din", 128'(tbl_din), 128'(0));
    chk("rst_tbl_tuple", 128'(tbl_tuple), 128'(0));

    // release and take the update on the very first edge
    @(posedge clk); #2; rst_n = 1'b1; #1;
    chk("upd_ready_first_edge", 128'(upd_ready), 128'(1));
    tick();
    chk("write_we", 128'(tbl_we), 128'(1));
    chk("write_index", 128'(tbl_index), 128'(5));
    chk("write_din", 128'(tbl_din), 128'(98'hA));
    upd_index = 11'd6; upd_data = 98'hB;
    chk("upd_ready_in_write", 128'(upd_ready), 128'(0));
    tick();
    chk("upd_ready_after_2", 128'(upd_ready), 128'(1));
    tick();
    upd_valid = 1'b0;
    chk("write2_index", 128'(tbl_index), 128'(6));
    tick(); tick();
    chk("we_dropped", 128'(tbl_we), 128'(0));

    // directed lookup vectors
    for (int v = 0; v < 10; v++) begin
      ev.m = vt[v].m; ev.r = vt[v].r; ev.h = vt[v].h;
      do_search(vt[v].st, mk_tuple(vt[v].key), ev);
      tick();
    end

    // burst cap: search held while six updates compete
    base_u = n_uacc;
    ev.m = 1'b1; ev.r = 11'd7; ev.h = 1;
    fork
      do_search(11'd3, mk_tuple(16'h1234), ev);
      begin
        for (int u = 0; u < 6; u++) do_upd1(IW'(100 + u), rnd_data());
        upd_valid = 1'b0;
      end
    join
    chk("burst_updates_first", 128'(u_at_sacc - base_u), 128'(UB));
    chk("updates_during_walk", 128'(u_at_res - u_at_sacc), 128'(0));
    chk("burst_total", 128'(n_uacc - base_u), 128'(6));
    repeat (3) tick();

    // reset pulsed during RD_WAIT of a cyclic walk
    b0 = n_acc; k = 0;
    search_valid = 1'b1; search_start_index = 11'd1; search_tuple = mk_tuple(16'h7777);
    while (n_acc == b0 && k < 50) begin tick(); k++; end
    search_valid = 1'b0;
    chk("walk_accepted", 128'(n_acc - b0), 128'(1));
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("arst_res_valid", 128'(res_valid), 128'(0));
    chk("arst_res_match", 128'(res_match), 128'(0));
    chk("arst_res_ruleID", 128'(res_ruleID), 128'(0));
    chk("arst_tbl_index", 128'(tbl_index), 128'(0));
    chk("arst_tbl_tuple", 128'(tbl_tuple), 128'(0));
    chk("arst_tbl_din", 128'(tbl_din), 128'(0));
    chk("arst_tbl_we", 128'(tbl_we), 128'(0));
    @(posedge clk); #2; rst_n = 1'b1;
    r0 = n_res;
    repeat (30) tick();
    chk("no_result_after_reset", 128'(n_res - r0), 128'(0));
    ev.m = 1'b1; ev.r = 11'd7; ev.h = 1;
    do_search(11'd3, mk_tuple(16'h1234), ev);
    tick();

    // randomized table and concurrent traffic
    for (int i = 0; i < 32; i++) begin
      mem_next[i] = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(0, 31));
      mem_hit[i]  = ($urandom_range(0, 2) == 0);
      mem_key[i]  = 16'($urandom_range(0, 3));
      mem_rule[i] = IW'($urandom_range(1, 2047));
    end
    fork
      begin
        logic [IW-1:0] rs_st;
        logic [PW-1:0] rs_tp;
        exp_t          rs_e;
        for (int s = 0; s < 40; s++) begin
          repeat ($urandom_range(0, 3)) tick();
          rs_st = IW'($urandom_range(0, 31));
          rs_tp = mk_tuple(16'($urandom_range(0, 3)));
          walk(rs_st, rs_tp, rs_e);
          do_search(rs_st, rs_tp, rs_e);
        end
      end
      begin
        for (int u = 0; u < 60; u++) begin
          repeat ($urandom_range(0, 3)) tick();
          do_upd1(IW'($urandom_range(0, 2047)), rnd_data());
          upd_valid = 1'b0;
        end
      end
    join
    repeat (5) tick();
    chk("pending_writes", 128'(wr_q.size()), 128'(0));
    chk("pending_results", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
